// File: rtl/sipo_frame_if.sv
// sipo_frame_if: serial-in and parallel-out handshake bundle for sipo_frame
interface sipo_frame_if #(parameter int WIDTH = 4);
  localparam int CW = $clog2(WIDTH + 1);
  logic             shift;
  logic             a;
  logic             flush;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             overrun;
  logic [CW-1:0]    bit_count;
  modport master(output shift, a, flush, out_ready, input out, out_valid, overrun, bit_count);
  modport slave(input shift, a, flush, out_ready, output out, out_valid, overrun, bit_count);
endinterface

// File: rtl/sipo_frame.sv
// sipo_frame: parametrised serial-in/parallel-out deserialiser with held output, flush and overrun
module sipo_frame #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  sipo_frame_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] r_sr, r_out, w_next_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_valid, r_ovr, w_done, w_free;
  assign w_next_sr = LSB_FIRST ? {bus.a, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], bus.a};
  assign w_done    = bus.shift & ~bus.flush & (r_cnt == CW'(WIDTH - 1));
  // the register is free if empty or being consumed on this very edge
  assign w_free    = ~r_valid | bus.out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else if (bus.shift) begin
        r_sr  <= w_next_sr;
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
      end
      if (w_done && w_free) begin
        r_out   <= w_next_sr;
        r_valid <= 1'b1;
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_done && !w_free) r_ovr <= 1'b1;
    end
  end
  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.overrun   = r_ovr;
  assign bus.bit_count = r_cnt;
endmodule

// File: tb/tb_sipo_frame.sv
// tb_sipo_frame: table-driven check of sipo_frame, LSB-first and MSB-first instances in lockstep
module tb_sipo_frame;
  typedef struct {
    logic [4:0] in;
    logic [3:0] ol;
    logic [3:0] om;
    logic [1:0] vo;
    logic [2:0] c;
  } vec_t;
  logic clk = 1'b0;
  logic reset, sh, a, fl, rdy;
  int   n = 0, errs = 0;
  vec_t tv[$];
  always #5 clk = ~clk;
  sipo_frame_if #(.WIDTH(4)) if_l ();
  sipo_frame_if #(.WIDTH(4)) if_m ();
  assign if_l.shift = sh;
  assign if_l.a = a;
  assign if_l.flush = fl;
  assign if_l.out_ready = rdy;
  assign if_m.shift = sh;
  assign if_m.a = a;
  assign if_m.flush = fl;
  assign if_m.out_ready = rdy;
  sipo_frame #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .reset(reset), .bus(if_l));
  sipo_frame #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
  function automatic vec_t mk(input logic [4:0] in, input logic [3:0] ol, om, input logic [1:0] vo, input logic [2:0] c);
    vec_t t;
    t.in = in;
    t.ol = ol;
    t.om = om;
    t.vo = vo;
    t.c  = c;
    return t;
  endfunction
  task automatic apply(input logic [4:0] in);
    {reset, sh, a, fl, rdy} = in;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] ol, om, input logic [1:0] vo, input logic [2:0] c);
    n++;
    if ({if_l.out, if_l.out_valid, if_l.overrun, if_l.bit_count} !== {ol, vo, c}) begin
      errs++;
      $display("FAIL %s lsb: got out=%b v=%b ovr=%b cnt=%0d want out=%b v=%b ovr=%b cnt=%0d",
               tag, if_l.out, if_l.out_valid, if_l.overrun, if_l.bit_count, ol, vo[1], vo[0], c);
    end
    n++;
    if ({if_m.out, if_m.out_valid, if_m.overrun, if_m.bit_count} !== {om, vo, c}) begin
      errs++;
      $display("FAIL %s msb: got out=%b v=%b ovr=%b cnt=%0d want out=%b v=%b ovr=%b cnt=%0d",
               tag, if_m.out, if_m.out_valid, if_m.overrun, if_m.bit_count, om, vo[1], vo[0], c);
    end
  endtask
  initial begin
    logic [3:0] bits;
    // inputs {reset, shift, a, flush, out_ready}; expected out lsb/msb, {valid, overrun}, bit_count
    tv.push_back(mk(5'b10000, 4'b0000, 4'b0000, 2'b00, 3'd0));
    tv.push_back(mk(5'b01101, 4'b0000, 4'b0000, 2'b00, 3'd1));
    tv.push_back(mk(5'b01001, 4'b0000, 4'b0000, 2'b00, 3'd2));
    tv.push_back(mk(5'b11101, 4'b0000, 4'b0000, 2'b00, 3'd0));
    tv.push_back(mk(5'b01101, 4'b0000, 4'b0000, 2'b00, 3'd1));
    tv.push_back(mk(5'b01001, 4'b0000, 4'b0000, 2'b00, 3'd2));
    tv.push_back(mk(5'b01101, 4'b0000, 4'b0000, 2'b00, 3'd3));
    tv.push_back(mk(5'b01101, 4'b1101, 4'b1011, 2'b10, 3'd0));
    tv.push_back(mk(5'b00001, 4'b1101, 4'b1011, 2'b00, 3'd0));
    tv.push_back(mk(5'b01101, 4'b1101, 4'b1011, 2'b00, 3'd1));
    tv.push_back(mk(5'b01001, 4'b1101, 4'b1011, 2'b00, 3'd2));
    tv.push_back(mk(5'b01001, 4'b1101, 4'b1011, 2'b00, 3'd3));
    tv.push_back(mk(5'b01001, 4'b0001, 4'b1000, 2'b10, 3'd0));
    tv.push_back(mk(5'b01001, 4'b0001, 4'b1000, 2'b00, 3'd1));
    tv.push_back(mk(5'b01101, 4'b0001, 4'b1000, 2'b00, 3'd2));
    tv.push_back(mk(5'b01101, 4'b0001, 4'b1000, 2'b00, 3'd3));
    tv.push_back(mk(5'b01101, 4'b1110, 4'b0111, 2'b10, 3'd0));
    tv.push_back(mk(5'b00001, 4'b1110, 4'b0111, 2'b00, 3'd0));
    tv.push_back(mk(5'b01100, 4'b1110, 4'b0111, 2'b00, 3'd1));
    tv.push_back(mk(5'b01100, 4'b1110, 4'b0111, 2'b00, 3'd2));
    tv.push_back(mk(5'b01000, 4'b1110, 4'b0111, 2'b00, 3'd3));
    tv.push_back(mk(5'b01000, 4'b0011, 4'b1100, 2'b10, 3'd0));
    tv.push_back(mk(5'b01100, 4'b0011, 4'b1100, 2'b10, 3'd1));
    tv.push_back(mk(5'b01100, 4'b0011, 4'b1100, 2'b10, 3'd2));
    tv.push_back(mk(5'b01100, 4'b0011, 4'b1100, 2'b10, 3'd3));
    tv.push_back(mk(5'b01100, 4'b0011, 4'b1100, 2'b11, 3'd0));
    tv.push_back(mk(5'b00001, 4'b0011, 4'b1100, 2'b01, 3'd0));
    tv.push_back(mk(5'b00001, 4'b0011, 4'b1100, 2'b01, 3'd0));
    tv.push_back(mk(5'b10000, 4'b0000, 4'b0000, 2'b00, 3'd0));
    tv.push_back(mk(5'b01100, 4'b0000, 4'b0000, 2'b00, 3'd1));
    tv.push_back(mk(5'b01000, 4'b0000, 4'b0000, 2'b00, 3'd2));
    tv.push_back(mk(5'b01100, 4'b0000, 4'b0000, 2'b00, 3'd3));
    tv.push_back(mk(5'b01000, 4'b0101, 4'b1010, 2'b10, 3'd0));
    tv.push_back(mk(5'b01000, 4'b0101, 4'b1010, 2'b10, 3'd1));
    tv.push_back(mk(5'b01100, 4'b0101, 4'b1010, 2'b10, 3'd2));
    tv.push_back(mk(5'b01000, 4'b0101, 4'b1010, 2'b10, 3'd3));
    tv.push_back(mk(5'b01101, 4'b1010, 4'b0101, 2'b10, 3'd0));
    tv.push_back(mk(5'b00001, 4'b1010, 4'b0101, 2'b00, 3'd0));
    tv.push_back(mk(5'b01101, 4'b1010, 4'b0101, 2'b00, 3'd1));
    tv.push_back(mk(5'b01101, 4'b1010, 4'b0101, 2'b00, 3'd2));
    tv.push_back(mk(5'b01101, 4'b1010, 4'b0101, 2'b00, 3'd3));
    tv.push_back(mk(5'b01011, 4'b1010, 4'b0101, 2'b00, 3'd0));
    tv.push_back(mk(5'b01001, 4'b1010, 4'b0101, 2'b00, 3'd1));
    tv.push_back(mk(5'b01001, 4'b1010, 4'b0101, 2'b00, 3'd2));
    tv.push_back(mk(5'b01001, 4'b1010, 4'b0101, 2'b00, 3'd3));
    tv.push_back(mk(5'b01101, 4'b1000, 4'b0001, 2'b10, 3'd0));
    tv.push_back(mk(5'b00001, 4'b1000, 4'b0001, 2'b00, 3'd0));
    {reset, sh, a, fl, rdy} = 5'b10000;
    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i].in);
      chk($sformatf("vec%0d", i), tv[i].ol, tv[i].om, tv[i].vo, tv[i].c);
    end
    // gapped bits 1,0,1,0 with three idle cycles after each; ready held low afterwards
    apply(5'b10000);
    bits = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      apply({2'b01, bits[i], 2'b00});
      chk($sformatf("gap_bit%0d", i), i == 3 ? 4'b0101 : 4'b0000, i == 3 ? 4'b1010 : 4'b0000,
          i == 3 ? 2'b10 : 2'b00, 3'((i + 1) % 4));
      for (int j = 0; j < 3; j++) begin
        apply(5'b00000);
        chk($sformatf("gap_idle%0d_%0d", i, j), i == 3 ? 4'b0101 : 4'b0000, i == 3 ? 4'b1010 : 4'b0000,
            i == 3 ? 2'b10 : 2'b00, 3'((i + 1) % 4));
      end
    end
    // a pending word survives a flush, then is consumed
    apply(5'b00000);
    apply(5'b01100);
    chk("pre_flush", 4'b0101, 4'b1010, 2'b10, 3'd1);
    apply(5'b01110);
    chk("flush_pending", 4'b0101, 4'b1010, 2'b10, 3'd0);
    apply(5'b00001);
    chk("consume_after_flush", 4'b0101, 4'b1010, 2'b00, 3'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule

// File: doc/sipo_frame.md
Name: sipo_frame

Overview:
- Parametrised serial-in/parallel-out deserialiser; next generation of the team's 4-bit right-shift SIPO.
- Collects WIDTH serial bits qualified by `shift` and presents each completed word on a held output register with a valid/ready handshake.
- Adds selectable bit order, frame flush and overrun detection.
- Sits between a serial bit source (serial adder result stream, serial link) and a parallel consumer.

Parameters:
- WIDTH, 4, word length in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = first received bit lands in out[0]; 0 = first received bit lands in out[WIDTH-1].
- CW, $clog2(WIDTH+1), width of the bit counter. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- shift  input  1  serial bit valid; `a` is sampled on every clk edge where shift=1.
- a  input  1  serial data bit.
- flush  input  1  discards the partial word in the shift register.
- out  output  WIDTH  completed parallel word; held stable while out_valid=1.
- out_valid  output  1  out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word; transfer occurs when out_valid & out_ready.
- overrun  output  1  sticky flag; a completed word was dropped.
- bit_count  output  CW  bits collected in the current partial word, 0..WIDTH-1.

Behaviour:
- Reset (sync, reset=1 at a clk edge):
  - out=0, out_valid=0, overrun=0, bit_count=0, shift register=0.
  - Reset overrides every other input, including mid-word and mid-handshake.
- Shift register sr[WIDTH-1:0]. On an edge with shift=1 and flush=0:
  - LSB_FIRST=1: sr <= {a, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], a}.
  - bit_count increments.
- Word completion: the edge where shift=1, flush=0 and bit_count==WIDTH-1.
  - The completed word, including the bit `a` sampled on that edge, is the candidate word.
  - bit_count wraps to 0 on the same edge.
  - No dead cycle: the next shift bit, on the following cycle, starts the next word.
- Output register, evaluated on a completion edge:
  - out_valid=0, or out_valid=1 with out_ready=1 (consumer frees the register this edge): out <= candidate word, out_valid <= 1.
  - out_valid=1 with out_ready=0: candidate word is dropped, overrun <= 1, out and out_valid are unchanged.
- Latency: out/out_valid update on the completion edge itself, so the word is visible in the cycle after the WIDTH-th bit is sampled.
- Handshake without completion: out_valid & out_ready at an edge sets out_valid <= 0; out keeps its last value.
- out_ready is ignored while out_valid=0.
- flush=1 at an edge:
  - sr <= 0 and bit_count <= 0.
  - A simultaneous shift bit is discarded, and no completion occurs that edge.
  - The output register and handshake are processed normally, so a pending word survives the flush.
- overrun clears only on reset.
- shift=0 with flush=0: sr and bit_count hold indefinitely; gaps between bits are legal.
- Implementation: fully synchronous, no combinational path from inputs to outputs.

Test Plan:
- Reset mid-word, WIDTH=4: shift in 1,0 then assert reset → next cycle out=0, out_valid=0, bit_count=0, overrun=0. A following 4-bit word assembles from scratch.
- LSB_FIRST=1, WIDTH=4, out_ready=1: shift bits 1,0,1,1 on consecutive cycles → out=4'b1101 and out_valid=1 the cycle after the 4th bit. The valid pulse lasts one cycle. Repeat with LSB_FIRST=0 → out=4'b1011.
- Back-to-back words, out_ready=1: 8 consecutive shift cycles carrying 1,0,0,0 then 0,1,1,1 → out=4'b0001 then 4'b1110 four cycles apart. No bit is lost and overrun stays 0.
- Backpressure, out_ready=0: complete word 4'b0011, then complete 4'b1111 → out stays 4'b0011, out_valid stays 1, overrun=1. Raise out_ready for one cycle → out_valid=0. Overrun remains 1 until reset.
- Simultaneous completion and handshake: out_valid=1 with 4'b0101 and out_ready=1 on the edge completing 4'b1010 → out=4'b1010, out_valid stays 1, overrun=0.
- Flush: shift 1,1,1, then flush=1 with shift=1, a=0 → bit_count=0, out unchanged. Next 4 bits 0,0,0,1 (LSB_FIRST=1) → out=4'b1000.
- Gapped input: bits 1,0,1,0 separated by 3 idle cycles each → out=4'b0101 after the 4th bit, with bit_count stepping 1,2,3,0.
